issue_stage: RTL and testbench
==============================

Name: issue_stage

Overview:
- Registered successor of the combinational decoder. It sits between the instruction fetcher and the ROB/RS/LSB.
- Decodes RV32I into a one-entry issue slot and snoops N_CDB result broadcast channels while an instruction waits.
- Applies backpressure to the fetcher when the ROB or the target unit is full.
- Resolves the same-cycle rename hazard against the instruction issuing ahead of it.

Parameters:
- XLEN, 32, data/address width.
- ROB_POS_W, 4, ROB index width. A rob id is ROB_POS_W+1 bits; the MSB=1 means "pending on ROB[pos]" and all-zero means "value valid".
- N_CDB, 2, number of result broadcast channels (ALU, LSB, ...).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, hold all state
- rollback  in  1  flush the slot
- if_inst_rdy  in  1  fetcher offers an instruction
- if_inst  in  32  instruction word
- if_inst_pc  in  XLEN  its pc
- if_inst_pred_jump  in  1  predictor's taken bit
- if_accept  out  1  slot takes the offered instruction this cycle
- reg_rs1, reg_rs2  out  5  regfile lookup index = if_inst fields
- reg_rs1_val, reg_rs2_val  in  XLEN  regfile values
- reg_rs1_rob_id, reg_rs2_rob_id  in  ROB_POS_W+1  regfile rename tags
- rob_rs1_pos, rob_rs2_pos  out  ROB_POS_W  ROB probe = tag[ROB_POS_W-1:0]
- rob_rs1_ready, rob_rs2_ready  in  1  probed entry has its result
- rob_rs1_val, rob_rs2_val  in  XLEN  probed entry value
- rob_nxt_pos  in  ROB_POS_W  ROB tail
- rob_full, rs_full, lsb_full  in  1  capacity flags
- cdb_valid  in  N_CDB  broadcast valid per channel
- cdb_rob_pos  in  N_CDB*ROB_POS_W  channel k occupies bits [k*ROB_POS_W +: ROB_POS_W]
- cdb_val  in  N_CDB*XLEN  channel k occupies bits [k*XLEN +: XLEN]
- issue  out  1  slot content is handed to ROB and RS/LSB this cycle
- rs_en, lsb_en  out  1  destination unit select, qualified by issue
- opcode 7, func3 3, func1 1, rd 5, imm XLEN, pc XLEN, pre_jump 1, is_store 1, is_ready 1  out  decoded slot fields
- rs1_val, rs2_val  out  XLEN; rs1_rob_id, rs2_rob_id  out  ROB_POS_W+1  operand value or pending tag
- rob_pos  out  ROB_POS_W  equals rob_nxt_pos

Behaviour:
- State: slot_valid plus registered decoded fields and operands.
- Reset (sync, rst=1): slot_valid=0 and every registered field=0. issue, rs_en, lsb_en and if_accept read 0.
- Stall condition: stall = rob_full | (slot_rs & rs_full) | (slot_lsb & lsb_full).
- Issue: issue = slot_valid & ~stall & ~rollback & rdy. rs_en = issue & slot_rs; lsb_en = issue & slot_lsb.
- Accept: if_accept = rdy & ~rollback & if_inst_rdy & (~slot_valid | issue).
- Edge update: if_accept loads the slot; issue without accept clears slot_valid; otherwise the slot holds. Latency from accept to earliest issue is 1 cycle.
- Decode per opcode:
  - LUI/AUIPC/JAL/JALR/ARITHI/ARITH/B go to RS; L/S go to LSB.
  - LUI/AUIPC/JAL: both operands = 0/ready.
  - JALR/ARITHI/L: rs2 = 0/ready.
  - B and S: rd=0.
  - S: is_store=1, is_ready=1.
  - Immediate formats: U, J, I, B, S, with sign extension to XLEN.
  - Unknown opcode: accepted, issued with rs_en=lsb_en=0 (dropped).
- Operand capture at accept, priority order:
  1. Source is x0 → value 0, ready.
  2. Same-cycle rename bypass: issue & slot rd!=0 & slot rd==src → tag {1,rob_nxt_pos}. This overrides the regfile, which has not yet seen the rename.
  3. Tag MSB=0 → regfile value.
  4. rob_ready → ROB value.
  5. Lowest-index CDB channel k with valid & pos match → cdb_val[k].
  6. Otherwise keep the tag.
- Snoop while held: each cycle, a pending operand whose pos matches a valid CDB channel takes the value and clears its tag to 0. The lowest k wins on duplicates.
- rollback: slot_valid←0 at the edge; issue=0 and if_accept=0 in that cycle.
- rdy=0: no state change; issue=0 and if_accept=0.

Optional Feature:
- Macro: ISSUE_STALL_CNT_EN.
- When defined, adds outputs stall_cycles (32) and issued_cnt (32):
  - stall_cycles increments on cycles with slot_valid & stall & rdy & ~rollback.
  - issued_cnt increments on issue.
  - Both wrap at 2^32 and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then offer ADDI x1,x0,5 at pc 0x0 → if_accept=1; next cycle issue=1, rs_en=1, imm=5, rs1_rob_id=0, rs1_val=0, rob_pos=rob_nxt_pos.
- Offer ADD x3,x1,x2 with reg_rs1_rob_id=5'h13, rob not ready, rs_full=1 for 3 cycles, CDB ch1 pos 3 val 0x2A in cycle 2 → held; after release issue=1, rs1_val=0x2A, rs1_rob_id=0.
- Back-to-back ADDI x1,x0,1 (issuing, rob_nxt_pos=6) then ADDI x2,x1,1 offered with regfile tag 0 → second captures rs1_rob_id=5'h16.
- SW x2,8(x1) → lsb_en=1, is_store=1, is_ready=1, rd=0, imm=8. Same with lsb_full=1 → if_accept drops after the slot fills, no issue.
- rollback asserted with slot valid → issue=0 that cycle, slot empty next cycle, no later issue of the flushed instruction.
- Two CDB channels broadcasting the same pos with 0x11 (ch0) and 0x22 (ch1) → operand captures 0x11.

Source files
------------

// File: rtl/issue_stage.sv
// issue_stage: one-entry registered issue slot between the fetcher and the
// ROB / RS / LSB. Decodes RV32I, captures operands (regfile, ROB, CDB or the
// same-cycle rename bypass), snoops the CDB while held, and backpressures the
// fetcher when the ROB or the target unit is full.
// Optional build macro ISSUE_STALL_CNT_EN adds stall_cycles / issued_cnt.
module issue_stage #(
  parameter int XLEN      = 32,
  parameter int ROB_POS_W = 4,
  parameter int N_CDB     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       rollback,
  input  logic                       if_inst_rdy,
  input  logic [31:0]                if_inst,
  input  logic [XLEN-1:0]            if_inst_pc,
  input  logic                       if_inst_pred_jump,
  output logic                       if_accept,
  output logic [4:0]                 reg_rs1,
  output logic [4:0]                 reg_rs2,
  input  logic [XLEN-1:0]            reg_rs1_val,
  input  logic [XLEN-1:0]            reg_rs2_val,
  input  logic [ROB_POS_W:0]         reg_rs1_rob_id,
  input  logic [ROB_POS_W:0]         reg_rs2_rob_id,
  output logic [ROB_POS_W-1:0]       rob_rs1_pos,
  output logic [ROB_POS_W-1:0]       rob_rs2_pos,
  input  logic                       rob_rs1_ready,
  input  logic                       rob_rs2_ready,
  input  logic [XLEN-1:0]            rob_rs1_val,
  input  logic [XLEN-1:0]            rob_rs2_val,
  input  logic [ROB_POS_W-1:0]       rob_nxt_pos,
  input  logic                       rob_full,
  input  logic                       rs_full,
  input  logic                       lsb_full,
  input  logic [N_CDB-1:0]           cdb_valid,
  input  logic [N_CDB*ROB_POS_W-1:0] cdb_rob_pos,
  input  logic [N_CDB*XLEN-1:0]      cdb_val,
  output logic                       issue,
  output logic                       rs_en,
  output logic                       lsb_en,
  output logic [6:0]                 opcode,
  output logic [2:0]                 func3,
  output logic                       func1,
  output logic [4:0]                 rd,
  output logic [XLEN-1:0]            imm,
  output logic [XLEN-1:0]            pc,
  output logic                       pre_jump,
  output logic                       is_store,
  output logic                       is_ready,
  output logic [XLEN-1:0]            rs1_val,
  output logic [XLEN-1:0]            rs2_val,
  output logic [ROB_POS_W:0]         rs1_rob_id,
  output logic [ROB_POS_W:0]         rs2_rob_id,
  output logic [ROB_POS_W-1:0]       rob_pos
`ifdef ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [31:0]                issued_cnt
`endif
);

  localparam int TAG_W = ROB_POS_W + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_ARITH  = 7'b0110011;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic            func1;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            pre_jump;
    logic            is_store;
    logic            is_ready;
    logic            is_rs;
    logic            is_lsb;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [TAG_W-1:0] rs1_id;
    logic [TAG_W-1:0] rs2_id;
  } slot_t;

  slot_t slot_q, slot_d, dec;
  logic  slot_valid_q, slot_valid_d;
  logic  use1, use2;
  logic  stall, issue_w, accept_w;
  logic  byp1, byp2;
  logic [31:0]            imm32;
  logic [XLEN:0]          cdb_cap1, cdb_cap2, cdb_snp1, cdb_snp2;
  logic [TAG_W+XLEN-1:0]  cap1, cap2;

  // Returns {hit, value}; channels are scanned high to low so the lowest index wins.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [ROB_POS_W-1:0]       pos,
    input logic [N_CDB-1:0]           v,
    input logic [N_CDB*ROB_POS_W-1:0] p,
    input logic [N_CDB*XLEN-1:0]      d
  );
    logic [XLEN:0] r;
    r = '0;
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (v[k] && (p[k*ROB_POS_W +: ROB_POS_W] == pos)) r = {1'b1, d[k*XLEN +: XLEN]};
    end
    return r;
  endfunction

  // Returns {tag, value} for one source operand in priority order.
  function automatic logic [TAG_W+XLEN-1:0] capture(
    input logic                 used,
    input logic [4:0]           src,
    input logic                 bypass,
    input logic [ROB_POS_W-1:0] nxt,
    input logic [XLEN-1:0]      rval,
    input logic [TAG_W-1:0]     rtag,
    input logic                 robr,
    input logic [XLEN-1:0]      robv,
    input logic [XLEN:0]        cdb
  );
    if (!used || src == 5'd0) return '0;
    // The regfile has not yet recorded the rename of the instruction issuing now.
    if (bypass) return {1'b1, nxt, {XLEN{1'b0}}};
    if (!rtag[TAG_W-1]) return {{TAG_W{1'b0}}, rval};
    if (robr) return {{TAG_W{1'b0}}, robv};
    if (cdb[XLEN]) return {{TAG_W{1'b0}}, cdb[XLEN-1:0]};
    return {rtag, {XLEN{1'b0}}};
  endfunction

  assign stall    = rob_full | (slot_q.is_rs & rs_full) | (slot_q.is_lsb & lsb_full);
  assign issue_w  = ~rst & rdy & ~rollback & slot_valid_q & ~stall;
  assign accept_w = ~rst & rdy & ~rollback & if_inst_rdy & (~slot_valid_q | issue_w);

  assign byp1 = issue_w && (slot_q.rd != 5'd0) && (slot_q.rd == if_inst[19:15]);
  assign byp2 = issue_w && (slot_q.rd != 5'd0) && (slot_q.rd == if_inst[24:20]);

  assign cdb_cap1 = cdb_lookup(reg_rs1_rob_id[ROB_POS_W-1:0], cdb_valid, cdb_rob_pos, cdb_val);
  assign cdb_cap2 = cdb_lookup(reg_rs2_rob_id[ROB_POS_W-1:0], cdb_valid, cdb_rob_pos, cdb_val);
  assign cdb_snp1 = cdb_lookup(slot_q.rs1_id[ROB_POS_W-1:0], cdb_valid, cdb_rob_pos, cdb_val);
  assign cdb_snp2 = cdb_lookup(slot_q.rs2_id[ROB_POS_W-1:0], cdb_valid, cdb_rob_pos, cdb_val);

  assign cap1 = capture(use1, if_inst[19:15], byp1, rob_nxt_pos, reg_rs1_val, reg_rs1_rob_id,
                        rob_rs1_ready, rob_rs1_val, cdb_cap1);
  assign cap2 = capture(use2, if_inst[24:20], byp2, rob_nxt_pos, reg_rs2_val, reg_rs2_rob_id,
                        rob_rs2_ready, rob_rs2_val, cdb_cap2);

  // Decode the offered instruction word into slot fields and operand usage.
  always_comb begin
    dec          = '0;
    use1         = 1'b0;
    use2         = 1'b0;
    imm32        = '0;
    dec.opcode   = if_inst[6:0];
    dec.func3    = if_inst[14:12];
    dec.func1    = if_inst[30];
    dec.rd       = if_inst[11:7];
    dec.pc       = if_inst_pc;
    dec.pre_jump = if_inst_pred_jump;
    case (if_inst[6:0])
      OP_LUI, OP_AUIPC: begin
        dec.is_rs = 1'b1;
        imm32     = {if_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.is_rs = 1'b1;
        imm32     = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
      end
      OP_JALR, OP_ARITHI: begin
        dec.is_rs = 1'b1;
        use1      = 1'b1;
        imm32     = {{20{if_inst[31]}}, if_inst[31:20]};
      end
      OP_ARITH: begin
        dec.is_rs = 1'b1;
        use1      = 1'b1;
        use2      = 1'b1;
      end
      OP_BRANCH: begin
        dec.is_rs = 1'b1;
        dec.rd    = 5'd0;
        use1      = 1'b1;
        use2      = 1'b1;
        imm32     = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
      end
      OP_LOAD: begin
        dec.is_lsb = 1'b1;
        use1       = 1'b1;
        imm32      = {{20{if_inst[31]}}, if_inst[31:20]};
      end
      OP_STORE: begin
        dec.is_lsb   = 1'b1;
        dec.is_store = 1'b1;
        dec.is_ready = 1'b1;
        dec.rd       = 5'd0;
        use1         = 1'b1;
        use2         = 1'b1;
        imm32        = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
      end
      // Unknown opcodes flow through and are dropped at issue; rd is cleared
      // so they never trigger the rename bypass.
      default: dec.rd = 5'd0;
    endcase
    dec.imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
  end

  // Slot next state: load on accept, clear on issue/rollback, otherwise hold and snoop.
  always_comb begin
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    if (rdy) begin
      if (rollback) begin
        slot_valid_d = 1'b0;
      end else if (accept_w) begin
        slot_valid_d   = 1'b1;
        slot_d         = dec;
        slot_d.rs1_id  = cap1[TAG_W+XLEN-1:XLEN];
        slot_d.rs1_val = cap1[XLEN-1:0];
        slot_d.rs2_id  = cap2[TAG_W+XLEN-1:XLEN];
        slot_d.rs2_val = cap2[XLEN-1:0];
      end else begin
        if (issue_w) slot_valid_d = 1'b0;
        if (slot_q.rs1_id[TAG_W-1] && cdb_snp1[XLEN]) begin
          slot_d.rs1_val = cdb_snp1[XLEN-1:0];
          slot_d.rs1_id  = '0;
        end
        if (slot_q.rs2_id[TAG_W-1] && cdb_snp2[XLEN]) begin
          slot_d.rs2_val = cdb_snp2[XLEN-1:0];
          slot_d.rs2_id  = '0;
        end
      end
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q       <= '0;
      slot_valid_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, issued_cnt_q;

  // Performance counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      issued_cnt_q <= '0;
    end else begin
      if (slot_valid_q & stall & rdy & ~rollback) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (issue_w) issued_cnt_q <= issued_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign issued_cnt   = issued_cnt_q;
`endif

  assign if_accept   = accept_w;
  assign issue       = issue_w;
  assign rs_en       = issue_w & slot_q.is_rs;
  assign lsb_en      = issue_w & slot_q.is_lsb;
  assign reg_rs1     = if_inst[19:15];
  assign reg_rs2     = if_inst[24:20];
  assign rob_rs1_pos = reg_rs1_rob_id[ROB_POS_W-1:0];
  assign rob_rs2_pos = reg_rs2_rob_id[ROB_POS_W-1:0];
  assign rob_pos     = rob_nxt_pos;
  assign opcode      = slot_q.opcode;
  assign func3       = slot_q.func3;
  assign func1       = slot_q.func1;
  assign rd          = slot_q.rd;
  assign imm         = slot_q.imm;
  assign pc          = slot_q.pc;
  assign pre_jump    = slot_q.pre_jump;
  assign is_store    = slot_q.is_store;
  assign is_ready    = slot_q.is_ready;
  assign rs1_val     = slot_q.rs1_val;
  assign rs2_val     = slot_q.rs2_val;
  assign rs1_rob_id  = slot_q.rs1_id;
  assign rs2_rob_id  = slot_q.rs2_id;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: decode table plus hand sequences for stall, snoop,
// rename bypass, rollback and rdy hold. Expected slot contents are queued
// when the DUT accepts and compared when it issues.
module tb_issue_stage;
  localparam int XLEN = 32;
  localparam int RW   = 4;
  localparam int NC   = 2;

  logic clk = 1'b0;
  logic rst, rdy, rollback, if_inst_rdy, if_inst_pred_jump, if_accept;
  logic [31:0] if_inst, if_inst_pc;
  logic [4:0] reg_rs1, reg_rs2;
  logic [31:0] reg_rs1_val, reg_rs2_val, rob_rs1_val, rob_rs2_val;
  logic [RW:0] reg_rs1_rob_id, reg_rs2_rob_id;
  logic [RW-1:0] rob_rs1_pos, rob_rs2_pos, rob_nxt_pos, rob_pos;
  logic rob_rs1_ready, rob_rs2_ready, rob_full, rs_full, lsb_full;
  logic [NC-1:0] cdb_valid;
  logic [NC*RW-1:0] cdb_rob_pos;
  logic [NC*XLEN-1:0] cdb_val;
  logic issue, rs_en, lsb_en, func1, pre_jump, is_store, is_ready;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [4:0] rd;
  logic [31:0] imm, pc, rs1_val, rs2_val;
  logic [RW:0] rs1_rob_id, rs2_rob_id;
`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_cycles, issued_cnt;
`endif

  issue_stage #(.XLEN(XLEN), .ROB_POS_W(RW), .N_CDB(NC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_inst_rdy(if_inst_rdy), .if_inst(if_inst), .if_inst_pc(if_inst_pc),
    .if_inst_pred_jump(if_inst_pred_jump), .if_accept(if_accept),
    .reg_rs1(reg_rs1), .reg_rs2(reg_rs2), .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val),
    .reg_rs1_rob_id(reg_rs1_rob_id), .reg_rs2_rob_id(reg_rs2_rob_id),
    .rob_rs1_pos(rob_rs1_pos), .rob_rs2_pos(rob_rs2_pos),
    .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
    .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val), .rob_nxt_pos(rob_nxt_pos),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
    .issue(issue), .rs_en(rs_en), .lsb_en(lsb_en), .opcode(opcode), .func3(func3),
    .func1(func1), .rd(rd), .imm(imm), .pc(pc), .pre_jump(pre_jump),
    .is_store(is_store), .is_ready(is_ready), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_rob_id(rs1_rob_id), .rs2_rob_id(rs2_rob_id), .rob_pos(rob_pos)
`ifdef ISSUE_STALL_CNT_EN
    , .stall_cycles(stall_cycles), .issued_cnt(issued_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f1;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        pj;
    logic        rs_en;
    logic        lsb_en;
    logic        st;
    logic [31:0] v1;
    logic [4:0]  t1;
    logic [31:0] v2;
    logic [4:0]  t2;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pj;
    logic [31:0] r1v;
    logic [4:0]  r1t;
    logic [31:0] r2v;
    logic [4:0]  r2t;
    logic        robr1;
    logic [31:0] robv1;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vq[$];
  exp_t cur_exp;
  bit   cur_exp_valid;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(
    input logic [6:0] opc, input logic [2:0] f3, input logic f1, input logic [4:0] rdv,
    input logic [31:0] immv, input logic [31:0] pcv, input logic pj,
    input logic rse, input logic lsbe, input logic st,
    input logic [31:0] v1, input logic [4:0] t1, input logic [31:0] v2, input logic [4:0] t2);
    exp_t e;
    e.opc = opc; e.f3 = f3; e.f1 = f1; e.rd = rdv; e.imm = immv; e.pc = pcv; e.pj = pj;
    e.rs_en = rse; e.lsb_en = lsbe; e.st = st; e.v1 = v1; e.t1 = t1; e.v2 = v2; e.t2 = t2;
    return e;
  endfunction

  function automatic void add_vec(
    input logic [31:0] inst, input logic [31:0] pcv, input logic pj,
    input logic [31:0] r1v, input logic [4:0] r1t, input logic [31:0] r2v, input logic [4:0] r2t,
    input logic robr1, input logic [31:0] robv1, input exp_t e);
    vec_t v;
    v.inst = inst; v.pc = pcv; v.pj = pj; v.r1v = r1v; v.r1t = r1t; v.r2v = r2v; v.r2t = r2t;
    v.robr1 = robr1; v.robv1 = robv1; v.e = e;
    vq.push_back(v);
  endfunction

  task automatic set_idle();
    rdy = 1'b1; rollback = 1'b0; if_inst_rdy = 1'b0; if_inst = '0; if_inst_pc = '0;
    if_inst_pred_jump = 1'b0; reg_rs1_val = '0; reg_rs2_val = '0;
    reg_rs1_rob_id = '0; reg_rs2_rob_id = '0; rob_rs1_ready = 1'b0; rob_rs2_ready = 1'b0;
    rob_rs1_val = '0; rob_rs2_val = '0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    cdb_valid = '0; cdb_rob_pos = '0; cdb_val = '0; cur_exp_valid = 1'b0;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pcv, input logic pj,
                       input logic [31:0] r1v, input logic [4:0] r1t,
                       input logic [31:0] r2v, input logic [4:0] r2t);
    if_inst_rdy = 1'b1; if_inst = inst; if_inst_pc = pcv; if_inst_pred_jump = pj;
    reg_rs1_val = r1v; reg_rs1_rob_id = r1t; reg_rs2_val = r2v; reg_rs2_rob_id = r2t;
  endtask

  // Scoreboard monitor, then advance one cycle back to the negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (issue) begin
      if (sb.size() == 0) begin
        chk("issue_without_entry", issue, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_rs_en", rs_en, e.rs_en);
        chk("sb_lsb_en", lsb_en, e.lsb_en);
        chk("sb_opcode", opcode, e.opc);
        chk("sb_func3", func3, e.f3);
        chk("sb_func1", func1, e.f1);
        chk("sb_rd", rd, e.rd);
        chk("sb_imm", imm, e.imm);
        chk("sb_pc", pc, e.pc);
        chk("sb_pre_jump", pre_jump, e.pj);
        chk("sb_is_store", is_store, e.st);
        chk("sb_is_ready", is_ready, e.st);
        chk("sb_rs1_rob_id", rs1_rob_id, e.t1);
        chk("sb_rs2_rob_id", rs2_rob_id, e.t2);
        if (e.t1 == 5'd0) chk("sb_rs1_val", rs1_val, e.v1);
        if (e.t2 == 5'd0) chk("sb_rs2_val", rs2_val, e.v2);
        chk("sb_rob_pos", rob_pos, rob_nxt_pos);
      end
    end
    if (if_accept) begin
      if (!cur_exp_valid) chk("accept_without_offer", if_accept, 0);
      else sb.push_back(cur_exp);
    end
    cur_exp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rob_nxt_pos = '0;
    set_idle();
    rst = 1'b1;
    offer(32'h00500093, 32'h0, 1'b0, 32'h0, 5'h0, 32'h0, 5'h0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    #1;
    chk("reset_if_accept", if_accept, 0);
    chk("reset_issue", issue, 0);
    chk("reset_rs_en", rs_en, 0);
    chk("reset_lsb_en", lsb_en, 0);
    chk("reset_opcode", opcode, 0);
    chk("reset_imm", imm, 0);
    chk("reset_rs1_rob_id", rs1_rob_id, 0);
    rst = 1'b0;
    set_idle();

    // Decode table: each vector is accepted and issues on the following cycle.
    add_vec(32'h00500093, 32'h0, 0, 32'hDEAD, 5'h13, 32'h0, 5'h0, 0, 32'h0,
            mk_exp(7'h13, 3'd0, 0, 5'd1, 32'h5, 32'h0, 0, 1, 0, 0, 32'h0, 5'h0, 32'h0, 5'h0));
    add_vec(32'h002081B3, 32'h4, 0, 32'h100, 5'h0, 32'h200, 5'h0, 0, 32'h0,
            mk_exp(7'h33, 3'd0, 0, 5'd3, 32'h0, 32'h4, 0, 1, 0, 0, 32'h100, 5'h0, 32'h200, 5'h0));
    add_vec(32'h402081B3, 32'h8, 0, 32'h5, 5'h0, 32'h3, 5'h0, 0, 32'h0,
            mk_exp(7'h33, 3'd0, 1, 5'd3, 32'h0, 32'h8, 0, 1, 0, 0, 32'h5, 5'h0, 32'h3, 5'h0));
    add_vec(32'h123452B7, 32'hC, 0, 32'h77, 5'h11, 32'h0, 5'h12, 0, 32'h0,
            mk_exp(7'h37, 3'd5, 0, 5'd5, 32'h12345000, 32'hC, 0, 1, 0, 0, 32'h0, 5'h0, 32'h0, 5'h0));
    add_vec(32'hFFFFF317, 32'h10, 0, 32'h0, 5'h0, 32'h0, 5'h0, 0, 32'h0,
            mk_exp(7'h17, 3'd7, 1, 5'd6, 32'hFFFFF000, 32'h10, 0, 1, 0, 0, 32'h0, 5'h0, 32'h0, 5'h0));
    add_vec(32'hFFDFF0EF, 32'h14, 1, 32'h0, 5'h13, 32'h0, 5'h0, 0, 32'h0,
            mk_exp(7'h6F, 3'd7, 1, 5'd1, 32'hFFFFFFFC, 32'h14, 1, 1, 0, 0, 32'h0, 5'h0, 32'h0, 5'h0));
    add_vec(32'hFFF08167, 32'h18, 0, 32'h0, 5'h15, 32'h0, 5'h12, 1, 32'hCAFE,
            mk_exp(7'h67, 3'd0, 1, 5'd2, 32'hFFFFFFFF, 32'h18, 0, 1, 0, 0, 32'hCAFE, 5'h0, 32'h0, 5'h0));
    add_vec(32'hFF812203, 32'h1C, 0, 32'h1000, 5'h0, 32'h0, 5'h0, 0, 32'h0,
            mk_exp(7'h03, 3'd2, 1, 5'd4, 32'hFFFFFFF8, 32'h1C, 0, 0, 1, 0, 32'h1000, 5'h0, 32'h0, 5'h0));
    add_vec(32'h0020A423, 32'h20, 0, 32'h2000, 5'h0, 32'h0, 5'h14, 0, 32'h0,
            mk_exp(7'h23, 3'd2, 0, 5'd0, 32'h8, 32'h20, 0, 0, 1, 1, 32'h2000, 5'h0, 32'h0, 5'h14));
    add_vec(32'hFE2088E3, 32'h24, 1, 32'h9, 5'h0, 32'h9, 5'h0, 0, 32'h0,
            mk_exp(7'h63, 3'd0, 1, 5'd0, 32'hFFFFFFF0, 32'h24, 1, 1, 0, 0, 32'h9, 5'h0, 32'h9, 5'h0));
    add_vec(32'h0000007F, 32'h28, 0, 32'h0, 5'h0, 32'h0, 5'h0, 0, 32'h0,
            mk_exp(7'h7F, 3'd0, 0, 5'd0, 32'h0, 32'h28, 0, 0, 0, 0, 32'h0, 5'h0, 32'h0, 5'h0));

    rob_nxt_pos = 4'd3;
    foreach (vq[i]) begin
      set_idle();
      offer(vq[i].inst, vq[i].pc, vq[i].pj, vq[i].r1v, vq[i].r1t, vq[i].r2v, vq[i].r2t);
      rob_rs1_ready = vq[i].robr1;
      rob_rs1_val   = vq[i].robv1;
      cur_exp = vq[i].e; cur_exp_valid = 1'b1;
      #1 chk("tbl_accept", if_accept, 1);
      tick();
      set_idle();
      #1 chk("tbl_issue", issue, 1);
      tick();
    end

    // Held behind rs_full while CDB channel 1 resolves rs1.
    set_idle();
    offer(32'h002081B3, 32'h40, 0, 32'h0, 5'h13, 32'h7, 5'h0);
    cur_exp = mk_exp(7'h33, 3'd0, 0, 5'd3, 32'h0, 32'h40, 0, 1, 0, 0, 32'h2A, 5'h0, 32'h7, 5'h0);
    cur_exp_valid = 1'b1;
    #1 chk("stall_accept", if_accept, 1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      set_idle();
      rs_full = 1'b1;
      offer(32'h00100093, 32'h44, 0, 32'h0, 5'h0, 32'h0, 5'h0);
      if (c == 2) begin
        cdb_valid = 2'b10;
        cdb_rob_pos = {4'd3, 4'd5};
        cdb_val = {32'h2A, 32'hBAD};
      end
      #1;
      chk("stall_issue", issue, 0);
      chk("stall_backpressure", if_accept, 0);
      if (c == 2) chk("stall_tag_pending", rs1_rob_id, 5'h13);
      if (c == 3) begin
        chk("snoop_rs1_tag", rs1_rob_id, 0);
        chk("snoop_rs1_val", rs1_val, 32'h2A);
      end
      tick();
    end
    set_idle();
    #1 chk("stall_release_issue", issue, 1);
    tick();

    // Same-cycle rename bypass.
    set_idle();
    rob_nxt_pos = 4'd5;
    offer(32'h00100093, 32'h80, 0, 32'h0, 5'h0, 32'h0, 5'h0);
    cur_exp = mk_exp(7'h13, 3'd0, 0, 5'd1, 32'h1, 32'h80, 0, 1, 0, 0, 32'h0, 5'h0, 32'h0, 5'h0);
    cur_exp_valid = 1'b1;
    tick();
    set_idle();
    rob_nxt_pos = 4'd6;
    offer(32'h00108113, 32'h84, 0, 32'h55, 5'h0, 32'h0, 5'h0);
    cur_exp = mk_exp(7'h13, 3'd0, 0, 5'd2, 32'h1, 32'h84, 0, 1, 0, 0, 32'h0, 5'h16, 32'h0, 5'h0);
    cur_exp_valid = 1'b1;
    #1;
    chk("b2b_issue", issue, 1);
    chk("b2b_accept", if_accept, 1);
    tick();
    set_idle();
    rob_nxt_pos = 4'd7;
    #1 chk("b2b_second_issue", issue, 1);
    tick();

    // Store held by lsb_full; rs_full must not stall it.
    set_idle();
    offer(32'h0020A423, 32'h50, 0, 32'h2000, 5'h0, 32'h33, 5'h0);
    cur_exp = mk_exp(7'h23, 3'd2, 0, 5'd0, 32'h8, 32'h50, 0, 0, 1, 1, 32'h2000, 5'h0, 32'h33, 5'h0);
    cur_exp_valid = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      set_idle();
      lsb_full = 1'b1;
      offer(32'h0020A423, 32'h54, 0, 32'h0, 5'h0, 32'h0, 5'h0);
      #1;
      chk("lsb_full_issue", issue, 0);
      chk("lsb_full_accept", if_accept, 0);
      tick();
    end
    set_idle();
    rs_full = 1'b1;
    #1 chk("lsb_release_issue", issue, 1);
    tick();

    // Rollback flushes the slot.
    set_idle();
    offer(32'h00500093, 32'h60, 0, 32'h0, 5'h0, 32'h0, 5'h0);
    cur_exp = mk_exp(7'h13, 3'd0, 0, 5'd1, 32'h5, 32'h60, 0, 1, 0, 0, 32'h0, 5'h0, 32'h0, 5'h0);
    cur_exp_valid = 1'b1;
    tick();
    set_idle();
    rollback = 1'b1;
    offer(32'h00500093, 32'h64, 0, 32'h0, 5'h0, 32'h0, 5'h0);
    #1;
    chk("rollback_issue", issue, 0);
    chk("rollback_accept", if_accept, 0);
    tick();
    sb.delete();
    for (int c = 0; c < 2; c++) begin
      set_idle();
      #1 chk("post_rollback_issue", issue, 0);
      tick();
    end

    // Duplicate CDB positions: channel 0 wins at capture and while held.
    set_idle();
    offer(32'h002081B3, 32'h70, 0, 32'h0, 5'h17, 32'h0, 5'h18);
    cdb_valid = 2'b11;
    cdb_rob_pos = {4'd7, 4'd7};
    cdb_val = {32'h22, 32'h11};
    cur_exp = mk_exp(7'h33, 3'd0, 0, 5'd3, 32'h0, 32'h70, 0, 1, 0, 0, 32'h11, 5'h0, 32'h33, 5'h0);
    cur_exp_valid = 1'b1;
    tick();
    set_idle();
    rs_full = 1'b1;
    cdb_valid = 2'b11;
    cdb_rob_pos = {4'd8, 4'd8};
    cdb_val = {32'h44, 32'h33};
    #1 chk("dup_cdb_hold_issue", issue, 0);
    tick();
    set_idle();
    #1 chk("dup_cdb_issue", issue, 1);
    tick();

    // rdy low holds everything; rob_full stalls.
    set_idle();
    offer(32'h00500093, 32'h90, 0, 32'h0, 5'h0, 32'h0, 5'h0);
    cur_exp = mk_exp(7'h13, 3'd0, 0, 5'd1, 32'h5, 32'h90, 0, 1, 0, 0, 32'h0, 5'h0, 32'h0, 5'h0);
    cur_exp_valid = 1'b1;
    tick();
    set_idle();
    rdy = 1'b0;
    offer(32'h00100093, 32'h94, 0, 32'h0, 5'h0, 32'h0, 5'h0);
    #1;
    chk("rdy_low_issue", issue, 0);
    chk("rdy_low_accept", if_accept, 0);
    tick();
    set_idle();
    rob_full = 1'b1;
    #1 chk("rob_full_issue", issue, 0);
    tick();
    set_idle();
    #1 chk("rob_release_issue", issue, 1);
    tick();
    set_idle();
    #1 chk("final_idle_issue", issue, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
